vector_floating_point_merge_sequencer: RTL

Parametrised, multi-cycle successor to the single-shot vector FP merge unit. It executes vfmerge.vfm (vm=0) and vfmv.v.f (vm=1) over a full VLEN register, LANES elements per cycle. It supports runtime SEW, vl clamping, tail-agnostic/undisturbed policy, NaN-boxing checks on the scalar operand, and valid/ready handshakes on both sides. It sits in the vector FP execute cluster between operand read and writeback.

---
 rtl/dragonfang_floating_point_pkg.sv | 23 ++
 rtl/vector_floating_point_merge_lane.sv | 61 ++++++
 rtl/vector_floating_point_merge_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/dragonfang_floating_point_pkg.sv
// Shared types and constants for the vector FP merge sequencer.
//   sew_fp_t       : runtime element width encoding (00 is illegal)
//   merge_state_t  : sequencer FSM states
//   CANONICAL_NAN_*: substituted for a badly NaN-boxed scalar operand
package dragonfang_floating_point_pkg;

  typedef enum logic [1:0] {
    SEW_ILLEGAL = 2'b00,
    SEW_FP16    = 2'b01,
    SEW_FP32    = 2'b10,
    SEW_FP64    = 2'b11
  } sew_fp_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } merge_state_t;

  localparam logic [15:0] CANONICAL_NAN_H = 16'h7E00;
  localparam logic [31:0] CANONICAL_NAN_S = 32'h7FC0_0000;

endpackage

// File: rtl/vector_floating_point_merge_lane.sv
// One element of vfmerge.vfm / vfmv.v.f, up to 64 bits wide (combinational).
//   sew_i     : element width
//   active_i  : element index below the effective vl
//   tail_i    : element index at or above the effective vl
//   vta_i     : tail agnostic (all-ones) when set, undisturbed otherwise
//   vm_i      : 1 selects the scalar unconditionally, 0 merges under mask_i
//   mask_i    : v0 bit for this element
//   vs2_i     : vector source element, zero-extended
//   vd_old_i  : prior destination element, zero-extended
//   fs1_i     : NaN-boxed scalar register
//   res_o     : result element; bits above SEW are zero-meaningless
module vector_floating_point_merge_lane
  import dragonfang_floating_point_pkg::*;
#(
  parameter int unsigned FLEN = 64
) (
  input  sew_fp_t           sew_i,
  input  logic              active_i,
  input  logic              tail_i,
  input  logic              vta_i,
  input  logic              vm_i,
  input  logic              mask_i,
  input  logic [63:0]       vs2_i,
  input  logic [63:0]       vd_old_i,
  input  logic [FLEN-1:0]   fs1_i,
  output logic [63:0]       res_o
);

  logic [63:0] sew_ones;
  logic [63:0] scalar;

  // Narrow scalars must be NaN-boxed; anything else becomes the canonical NaN.
  always_comb begin : pick
    sew_ones = '0;
    scalar   = '0;
    res_o    = vd_old_i;
    case (sew_i)
      SEW_FP16: begin
        sew_ones = 64'(16'hFFFF);
        scalar   = (&fs1_i[FLEN-1:16]) ? 64'(fs1_i[15:0]) : 64'(CANONICAL_NAN_H);
      end
      SEW_FP32: begin
        sew_ones = 64'(32'hFFFF_FFFF);
        scalar   = (&fs1_i[FLEN-1:32]) ? 64'(fs1_i[31:0]) : 64'(CANONICAL_NAN_S);
      end
      SEW_FP64: begin
        sew_ones = '1;
        scalar   = 64'(fs1_i);
      end
      default: ;
    endcase
    if (tail_i) begin
      res_o = vta_i ? sew_ones : vd_old_i;
    end else if (active_i && !vm_i && !mask_i) begin
      res_o = vs2_i;
    end else begin
      res_o = scalar;
    end
  end

endmodule

// File: rtl/vector_floating_point_merge_sequencer.sv
// Multi-cycle vfmerge.vfm / vfmv.v.f over a VLEN register, LANES elements per cycle.
//   clock, reset         : clock, asynchronous active-high reset
//   in_valid / in_ready  : request handshake; operands sampled on the accepting edge
//   sew, vl, vm, vta     : element width, active length, move/merge select, tail policy
//   fs1, v0, vs2, vd_old : scalar, mask, vector source, prior destination
//   out_valid / out_ready: result handshake; vd and illegal held while out_valid
module vector_floating_point_merge_sequencer
  import dragonfang_floating_point_pkg::*;
#(
  parameter int unsigned VLEN  = 128,
  parameter int unsigned LANES = 2,
  parameter int unsigned FLEN  = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               sew,
  input  logic [$clog2(VLEN/16):0] vl,
  input  logic                     vm,
  input  logic                     vta,
  input  logic [FLEN-1:0]          fs1,
  input  logic [VLEN-1:0]          v0,
  input  logic [VLEN-1:0]          vs2,
  input  logic [VLEN-1:0]          vd_old,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [VLEN-1:0]          vd,
  output logic                     illegal
);

  localparam int unsigned IDXW = $clog2(VLEN/16) + 1;
  localparam int unsigned BW   = $clog2(VLEN);

  merge_state_t    state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [VLEN-1:0] vd_q, vd_d;
  logic            illegal_q, illegal_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  sew_fp_t         sew_q;
  logic [IDXW-1:0] eff_vl_q;
  logic            vm_q, vta_q;
  logic [FLEN-1:0] fs1_q;
  logic [VLEN-1:0] v0_q, vs2_q, vd_old_q;

  logic            accept_c;
  logic [IDXW-1:0] elems_in_c, eff_vl_in_c, elems_c;
  logic [2:0]      sew_shift_c;
  logic            last_beat_c;

  logic [63:0]     lane_res [LANES];
  logic [BW-1:0]   lane_off [LANES];
  logic            lane_ok  [LANES];

  // Elements per register for a given SEW; zero for the illegal encoding.
  function automatic logic [IDXW-1:0] elems_for(input sew_fp_t s);
    case (s)
      SEW_FP16: return IDXW'(VLEN/16);
      SEW_FP32: return IDXW'(VLEN/32);
      SEW_FP64: return IDXW'(VLEN/64);
      default:  return '0;
    endcase
  endfunction

  assign accept_c    = in_ready_q && in_valid;
  assign elems_in_c  = elems_for(sew_fp_t'(sew));
  assign eff_vl_in_c = (vl > elems_in_c) ? elems_in_c : vl;
  assign elems_c     = elems_for(sew_q);
  assign last_beat_c = ({1'b0, idx_q} + (IDXW+1)'(LANES)) >= {1'b0, elems_c};

  // log2 of the element width in bits, used to turn an element index into a bit offset.
  always_comb begin : shift_sel
    sew_shift_c = 3'd0;
    case (sew_q)
      SEW_FP16: sew_shift_c = 3'd4;
      SEW_FP32: sew_shift_c = 3'd5;
      SEW_FP64: sew_shift_c = 3'd6;
      default:  ;
    endcase
  end

  // Operand capture; only the accepting edge loads, so later input changes are ignored.
  always_ff @(posedge clock or posedge reset) begin : capture
    if (reset) begin
      sew_q    <= SEW_ILLEGAL;
      eff_vl_q <= '0;
      vm_q     <= 1'b0;
      vta_q    <= 1'b0;
      fs1_q    <= '0;
      v0_q     <= '0;
      vs2_q    <= '0;
      vd_old_q <= '0;
    end else if (accept_c) begin
      sew_q    <= sew_fp_t'(sew);
      eff_vl_q <= eff_vl_in_c;
      vm_q     <= vm;
      vta_q    <= vta;
      fs1_q    <= fs1;
      v0_q     <= v0;
      vs2_q    <= vs2;
      vd_old_q <= vd_old;
    end
  end

  // Lane datapath: element idx+l; lanes past the last element (N < LANES) are dropped.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [IDXW-1:0] elem;
    logic [63:0]     vs2_e, vdo_e;
    logic            tail;

    assign elem        = idx_q + IDXW'(l);
    assign lane_ok[l]  = elem < elems_c;
    assign lane_off[l] = BW'(elem) << sew_shift_c;
    assign tail        = elem >= eff_vl_q;

    always_comb begin : slice
      vs2_e = '0;
      vdo_e = '0;
      case (sew_q)
        SEW_FP16: begin
          vs2_e = 64'(vs2_q[lane_off[l] +: 16]);
          vdo_e = 64'(vd_old_q[lane_off[l] +: 16]);
        end
        SEW_FP32: begin
          vs2_e = 64'(vs2_q[lane_off[l] +: 32]);
          vdo_e = 64'(vd_old_q[lane_off[l] +: 32]);
        end
        SEW_FP64: begin
          vs2_e = vs2_q[lane_off[l] +: 64];
          vdo_e = vd_old_q[lane_off[l] +: 64];
        end
        default: ;
      endcase
    end

    vector_floating_point_merge_lane #(.FLEN(FLEN)) u_lane (
      .sew_i    (sew_q),
      .active_i (!tail),
      .tail_i   (tail),
      .vta_i    (vta_q),
      .vm_i     (vm_q),
      .mask_i   (v0_q[BW'(elem)]),
      .vs2_i    (vs2_e),
      .vd_old_i (vdo_e),
      .fs1_i    (fs1_q),
      .res_o    (lane_res[l])
    );
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin : fsm_regs
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      vd_q        <= '0;
      illegal_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      vd_q        <= vd_d;
      illegal_q   <= illegal_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next state: accept, LANES elements per BUSY cycle, hold result until out_ready.
  always_comb begin : fsm_next
    state_d     = state_q;
    idx_d       = idx_q;
    vd_d        = vd_q;
    illegal_d   = illegal_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          idx_d      = '0;
          in_ready_d = 1'b0;
          if (sew_fp_t'(sew) == SEW_ILLEGAL) begin
            vd_d        = vd_old;
            illegal_d   = 1'b1;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            illegal_d = 1'b0;
            state_d   = BUSY;
          end
        end
      end
      BUSY: begin
        for (int l = 0; l < LANES; l++) begin
          if (lane_ok[l]) begin
            case (sew_q)
              SEW_FP16: vd_d[lane_off[l] +: 16] = lane_res[l][15:0];
              SEW_FP32: vd_d[lane_off[l] +: 32] = lane_res[l][31:0];
              SEW_FP64: vd_d[lane_off[l] +: 64] = lane_res[l];
              default:  ;
            endcase
          end
        end
        idx_d = idx_q + IDXW'(LANES);
        if (last_beat_c) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign vd        = vd_q;
  assign illegal   = illegal_q;

endmodule
